// File: rtl/kong_sprite_pkg.sv
// Shared constants, frame-index encoding and sprite texel art for the kong sprite renderer.
package kong_sprite_pkg;

  // Screen limits; the scan counter widths follow from them.
  localparam int unsigned SCR_W   = 640;
  localparam int unsigned SCR_H   = 480;
  localparam int unsigned HCNT_W  = $clog2(SCR_W);
  localparam int unsigned VCNT_W  = $clog2(SCR_H);

  // Sprite geometry (power-of-two sides).
  localparam int unsigned SPR_W   = 32;
  localparam int unsigned SPR_H   = 32;
  localparam int unsigned COL_W   = $clog2(SPR_W);
  localparam int unsigned ROW_W   = $clog2(SPR_H);
  localparam int unsigned FRAME_W = 3;
  localparam int unsigned ADDR_W  = FRAME_W + ROW_W + COL_W;
  localparam int unsigned RGB_W   = 12;

  // Right and bottom box limits are one bit wider so they clip instead of wrapping.
  localparam int unsigned H_SUM_W = HCNT_W + 1;
  localparam int unsigned V_SUM_W = VCNT_W + 1;

  localparam logic [RGB_W-1:0] TRANSP_KEY = 12'h000;

  typedef logic [FRAME_W-1:0] frame_idx_t;

  // Row-major ROM address: frame f occupies f*1024 .. f*1024+1023.
  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
  } rom_addr_t;

  // Eight animation frames: the animation group plus the top bit of the animation counter.
  function automatic frame_idx_t frame_idx(input logic [1:0] anim_state, input logic anicnt_msb);
    return {anim_state, anicnt_msb};
  endfunction

  // Procedural kong art: every 8th row and the last column are see-through.
  function automatic logic [RGB_W-1:0] sprite_texel(input rom_addr_t a);
    if ((a.row[2:0] == 3'd7) || (a.col == 5'd31)) begin
      return TRANSP_KEY;
    end
    return {1'b1, a.frame, a.row[4:1], a.col[4:1]};
  endfunction

endpackage

// File: rtl/kong_sprite_rom.sv
// 8192 x 12 sprite ROM with a registered read port (1-cycle latency).
module kong_sprite_rom
  import kong_sprite_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  rom_addr_t        addr,
  output logic [RGB_W-1:0] data
);

  logic [RGB_W-1:0] data_d;
  logic [RGB_W-1:0] data_q;

  // Texel lookup for the presented address.
  always_comb begin
    data_d = sprite_texel(addr);
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/kong_sprite.sv
// Kong sprite pixel renderer: per-frame shadow of kong's pose and a fixed 3-stage ROM pipeline.
module kong_sprite
  import kong_sprite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              de,
  input  logic [HCNT_W-1:0] hcnt,
  input  logic [VCNT_W-1:0] vcnt,
  input  logic [HCNT_W-1:0] kong_x,
  input  logic [VCNT_W-1:0] kong_y,
  input  logic              kong_state,
  input  logic [1:0]        animation_state,
  input  logic [3:0]        anicnt,
  output logic              pix_valid,
  output logic [RGB_W-1:0]  pix_rgb,
  output logic              pix_de
);

  logic [HCNT_W-1:0] sx_d, sx_q;
  logic [VCNT_W-1:0] sy_d, sy_q;
  frame_idx_t        sframe_d, sframe_q;
  logic              shide_d, shide_q;

  logic [H_SUM_W-1:0] h_end_c;
  logic [V_SUM_W-1:0] v_end_c;
  logic               in_box_d1_d, in_box_d1_q;
  logic               de_d1_d, de_d1_q;
  rom_addr_t          rom_addr_d, rom_addr_q;
  logic               in_box_d2_q, de_d2_q;
  logic [RGB_W-1:0]   rom_data;
  logic               pix_valid_d, pix_valid_q;
  logic [RGB_W-1:0]   pix_rgb_d, pix_rgb_q;
  logic               pix_de_q;

  // Only the animation counter MSB selects a frame; the low bits are ignored.
  logic unused_anicnt;
  assign unused_anicnt = ^anicnt[2:0];

  // Shadow kong's pose once per frame so a frame is never torn.
  always_comb begin
    sx_d     = sx_q;
    sy_d     = sy_q;
    sframe_d = sframe_q;
    shide_d  = shide_q;
    if (frame_tick) begin
      sx_d     = kong_x;
      sy_d     = kong_y;
      sframe_d = frame_idx(animation_state, anicnt[3]);
      shide_d  = ~kong_state;
    end
  end

  // Stage 1: box test against the shadow pose and ROM address formation.
  always_comb begin
    h_end_c     = {1'b0, sx_q} + H_SUM_W'(SPR_W);
    v_end_c     = {1'b0, sy_q} + V_SUM_W'(SPR_H);
    in_box_d1_d = de & ~shide_q
                & (hcnt >= sx_q) & ({1'b0, hcnt} < h_end_c)
                & (vcnt >= sy_q) & ({1'b0, vcnt} < v_end_c);
    de_d1_d     = de;
    rom_addr_d.frame = sframe_q;
    rom_addr_d.row   = ROW_W'(vcnt - sy_q);
    rom_addr_d.col   = COL_W'(hcnt - sx_q);
  end

  kong_sprite_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr_q),
    .data (rom_data)
  );

  // Stage 3: key out transparent texels and force colour to zero off-sprite.
  always_comb begin
    pix_valid_d = in_box_d2_q & (rom_data != TRANSP_KEY);
    pix_rgb_d   = pix_valid_d ? rom_data : '0;
  end

  // Shadow registers and pipeline flops; reset hides the sprite until the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q        <= '0;
      sy_q        <= '0;
      sframe_q    <= '0;
      shide_q     <= 1'b1;
      in_box_d1_q <= 1'b0;
      de_d1_q     <= 1'b0;
      rom_addr_q  <= '0;
      in_box_d2_q <= 1'b0;
      de_d2_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_rgb_q   <= '0;
      pix_de_q    <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sframe_q    <= sframe_d;
      shide_q     <= shide_d;
      in_box_d1_q <= in_box_d1_d;
      de_d1_q     <= de_d1_d;
      rom_addr_q  <= rom_addr_d;
      in_box_d2_q <= in_box_d1_q;
      de_d2_q     <= de_d1_q;
      pix_valid_q <= pix_valid_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_de_q    <= de_d2_q;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_rgb   = pix_rgb_q;
  assign pix_de    = pix_de_q;

endmodule

// File: tb/tb_kong_sprite.sv
// Scoreboard bench for kong_sprite: stimulus queues expected pixels, a monitor checks them 3 edges later.
module tb_kong_sprite;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  hcnt = '0;
  logic [8:0]  vcnt = '0;
  logic [9:0]  kong_x = '0;
  logic [8:0]  kong_y = '0;
  logic        kong_state = 1'b0;
  logic [1:0]  animation_state = '0;
  logic [3:0]  anicnt = '0;
  logic        pix_valid;
  logic [11:0] pix_rgb;
  logic        pix_de;

  kong_sprite dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .de              (de),
    .hcnt            (hcnt),
    .vcnt            (vcnt),
    .kong_x          (kong_x),
    .kong_y          (kong_y),
    .kong_state      (kong_state),
    .animation_state (animation_state),
    .anicnt          (anicnt),
    .pix_valid       (pix_valid),
    .pix_rgb         (pix_rgb),
    .pix_de          (pix_de)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    int          h;
    int          v;
    bit          ev;
    logic [11:0] ergb;
    bit          ede;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference shadow of kong's pose, updated only when the bench issues a tick.
  int m_sx = 0, m_sy = 0, m_frame = 0;
  bit m_hide = 1'b1;

  // Independent model of the sprite art.
  function automatic logic [11:0] ref_rom(input int f, input int r, input int c);
    if (((r % 8) == 7) || (c == 31)) return 12'h000;
    return 12'(2048 + f * 256 + (r / 2) * 16 + (c / 2));
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_frame = 0; m_hide = 1'b1;
  endtask

  task automatic chk_direct(input string nm, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // One scan cycle: drive inputs, queue the expected pixel for 3 edges later.
  task automatic step(input int h, input int v, input bit d, input bit tk);
    exp_t e;
    bit ib;
    logic [11:0] c;
    @(negedge clk);
    hcnt = 10'(h); vcnt = 9'(v); de = d; frame_tick = tk;
    ib = d && !m_hide && (h >= m_sx) && (h < m_sx + 32) && (v >= m_sy) && (v < m_sy + 32);
    c = ib ? ref_rom(m_frame, v - m_sy, h - m_sx) : 12'h000;
    e.tgt = cyc + 3; e.h = h; e.v = v;
    e.ev = ib && (c != 12'h000);
    e.ergb = e.ev ? c : 12'h000;
    e.ede = d;
    q.push_back(e);
    if (tk) begin
      m_sx = int'(kong_x); m_sy = int'(kong_y);
      m_frame = int'({animation_state, anicnt[3]});
      m_hide = !kong_state;
    end
  endtask

  task automatic set_kong(input int x, input int y, input bit st, input int an, input int ac);
    kong_x = 10'(x); kong_y = 9'(y); kong_state = st;
    animation_state = 2'(an); anicnt = 4'(ac);
  endtask

  task automatic scan_row(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v, 1'b1, 1'b0);
  endtask

  // Monitor: compare each queued pixel when its output cycle arrives.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pix_valid !== e.ev || pix_rgb !== e.ergb || pix_de !== e.ede) begin
        failures++;
        $display("FAIL pix(%0d,%0d): got valid=%b rgb=%h de=%b expected valid=%b rgb=%h de=%b",
                 e.h, e.v, pix_valid, pix_rgb, pix_de, e.ev, e.ergb, e.ede);
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_direct("reset_outputs", {pix_valid, pix_de, pix_rgb}, 14'h0);
    rst = 1'b0;

    // No tick yet: sprite stays hidden over a sampled frame sweep.
    set_kong(100, 50, 1'b1, 0, 0);
    for (int v = 0; v < 480; v += 16) scan_row(v, 0, 639);
    scan_row(50, 90, 140);

    // Tick at (100,50), frame 0; edges and interior.
    step(0, 0, 1'b0, 1'b1);
    step(100, 50, 1'b1, 1'b0);
    step(132, 50, 1'b1, 1'b0);
    step(99, 50, 1'b1, 1'b0);
    step(131, 81, 1'b1, 1'b0);
    step(131, 82, 1'b1, 1'b0);
    step(105, 57, 1'b1, 1'b0);
    step(110, 60, 1'b1, 1'b0);
    step(110, 60, 1'b0, 1'b0);
    step(110, 49, 1'b1, 1'b0);

    // Frame 5 at origin.
    set_kong(0, 0, 1'b1, 2, 8);
    step(0, 0, 1'b0, 1'b1);
    step(3, 2, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    step(31, 31, 1'b1, 1'b0);
    step(30, 30, 1'b1, 1'b0);

    // Right-edge clipping: no wrap into low columns.
    set_kong(620, 100, 1'b1, 1, 0);
    step(0, 0, 1'b0, 1'b1);
    for (int v = 100; v < 104; v++) begin
      scan_row(v, 610, 639);
      scan_row(v, 0, 11);
    end

    // Mid-frame kong_x change has no effect until the next tick; tick during de=1.
    set_kong(100, 50, 1'b1, 0, 0);
    step(0, 0, 1'b0, 1'b1);
    scan_row(52, 95, 140);
    kong_x = 10'd300;
    scan_row(53, 95, 140);
    scan_row(53, 295, 335);
    step(120, 54, 1'b1, 1'b1);
    step(120, 54, 1'b1, 1'b0);
    scan_row(55, 95, 140);
    scan_row(55, 295, 335);

    // Hidden kong.
    set_kong(300, 50, 1'b0, 0, 0);
    step(0, 0, 1'b0, 1'b1);
    for (int v = 50; v < 82; v += 5) scan_row(v, 295, 335);

    // Async reset mid-line; tick during reset is ignored.
    set_kong(100, 50, 1'b1, 3, 15);
    step(0, 0, 1'b0, 1'b1);
    scan_row(56, 100, 110);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_direct("rst_async", {pix_valid, pix_de, pix_rgb}, 14'h0);
    q.delete();
    de = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk_direct("rst_hold", {pix_valid, pix_de, pix_rgb}, 14'h0);
    rst = 1'b0;
    model_reset();
    scan_row(56, 95, 140);
    step(0, 0, 1'b0, 1'b1);
    scan_row(56, 95, 140);

    // Drain with a bounded wait.
    step(0, 0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d pixels still pending, expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
